// File: rtl/score_tracker.sv
// Multi-channel game score tracker: saturating per-channel scores with combo doubling,
// a session high score, and registered BCD/leader display outputs.
module score_tracker #(
  parameter int NUM_CH       = 2,
  parameter int DIGITS       = 2,
  parameter int MAX_SCORE    = 99,
  parameter int COMBO_LEN    = 4,
  parameter int MISS_PENALTY = 1,
  localparam int LW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [NUM_CH-1:0]          hit_pulse,
  input  logic [NUM_CH-1:0]          miss_pulse,
  output logic [NUM_CH*DIGITS*4-1:0] score_bcd,
  output logic [NUM_CH-1:0]          combo_active,
  output logic [DIGITS*4-1:0]        high_score_bcd,
  output logic [LW-1:0]              leader
);

  localparam int SW  = $clog2(MAX_SCORE + 1);
  localparam int STW = $clog2(COMBO_LEN + 1);
  localparam logic [SW-1:0]  MAX_V   = SW'(MAX_SCORE);
  localparam logic [STW-1:0] COMBO_V = STW'(COMBO_LEN);

  logic [SW-1:0]  score     [NUM_CH];
  logic [SW-1:0]  score_nx  [NUM_CH];
  logic [STW-1:0] streak    [NUM_CH];
  logic [STW-1:0] streak_nx [NUM_CH];
  logic [SW-1:0]  high_score;
  logic [SW-1:0]  max_score;
  logic [LW-1:0]  lead_idx;

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic dbl);
    logic [31:0] s;
    s = 32'(a) + (dbl ? 32'd2 : 32'd1);
    return (s > 32'(MAX_SCORE)) ? MAX_V : SW'(s);
  endfunction

  function automatic logic [SW-1:0] sat_sub(input logic [SW-1:0] a);
    logic [31:0] d;
    d = 32'(a);
    return (d > 32'(MISS_PENALTY)) ? SW'(d - 32'(MISS_PENALTY)) : '0;
  endfunction

  // Double-dabble: exact for any value that fits in DIGITS decimal digits.
  function automatic logic [DIGITS*4-1:0] to_bcd(input logic [SW-1:0] v);
    logic [DIGITS*4-1:0] b;
    b = '0;
    for (int i = SW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++)
        if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
      b = {b[DIGITS*4-2:0], v[i]};
    end
    return b;
  endfunction

  // A simultaneous miss wins over a hit; clear overrides everything.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      score_nx[i]  = score[i];
      streak_nx[i] = streak[i];
      if (clear) begin
        score_nx[i]  = '0;
        streak_nx[i] = '0;
      end else if (enable) begin
        if (miss_pulse[i]) begin
          score_nx[i]  = sat_sub(score[i]);
          streak_nx[i] = '0;
        end else if (hit_pulse[i]) begin
          score_nx[i]  = sat_add(score[i], combo_active[i]);
          streak_nx[i] = (streak[i] == COMBO_V) ? streak[i] : streak[i] + 1'b1;
        end
      end
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    max_score = '0;
    lead_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (score[i] > max_score) begin
        max_score = score[i];
        lead_idx  = LW'(i);
      end
    end
  end

  // Stage 0: score, streak and combo flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        score[i]  <= '0;
        streak[i] <= '0;
      end
      combo_active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        score[i]        <= score_nx[i];
        streak[i]       <= streak_nx[i];
        combo_active[i] <= (streak_nx[i] == COMBO_V);
      end
    end
  end

  // Stage 1: display conversion, leader and binary high score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd  <= '0;
      leader     <= '0;
      high_score <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        score_bcd[i*DIGITS*4 +: DIGITS*4] <= to_bcd(score[i]);
      leader <= lead_idx;
      if (max_score > high_score) high_score <= max_score;
    end
  end

  // Stage 2: high score display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) high_score_bcd <= '0;
    else        high_score_bcd <= to_bcd(high_score);
  end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent player channels (1..8).
REQ-002 Parameter DIGITS, default 2, BCD digits per displayed score.
REQ-003 Parameter MAX_SCORE, default 99, saturation ceiling; SHALL be <= 10^DIGITS-1.
REQ-004 Parameter COMBO_LEN, default 4, consecutive hits needed to arm double points (>=1).
REQ-005 Parameter MISS_PENALTY, default 1, points subtracted per miss.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  game running; hit/miss ignored when low.
REQ-009 clear  input  1  synchronous game restart.
REQ-010 hit_pulse  input  NUM_CH  one-cycle hit strobe per channel.
REQ-011 miss_pulse  input  NUM_CH  one-cycle miss strobe per channel.
REQ-012 score_bcd  output  NUM_CH*DIGITS*4  per-channel BCD score; channel 0 in LSBs.
REQ-013 combo_active  output  NUM_CH  per-channel double-points armed flag.
REQ-014 high_score_bcd  output  DIGITS*4  session high score, BCD.
REQ-015 leader  output  max(1,$clog2(NUM_CH))  index of channel with highest score.

Function
REQ-016 Each channel SHALL hold a binary score (width $clog2(MAX_SCORE+1)) and a streak counter saturating at COMBO_LEN.
REQ-017 combo_active[i] SHALL be registered, high exactly when streak[i] == COMBO_LEN.
REQ-018 Hit (enable=1, clear=0, hit_pulse[i]=1, miss_pulse[i]=0): score += 2 if combo_active[i] before the edge, else +1; streak += 1 (saturating).
REQ-019 Score addition SHALL saturate: new score = min(score+points, MAX_SCORE); no wrap.
REQ-020 Miss (enable=1, clear=0, miss_pulse[i]=1): score = max(score-MISS_PENALTY, 0); streak = 0.
REQ-021 hit_pulse[i] and miss_pulse[i] in the same cycle SHALL be treated as a miss only.
REQ-022 Channels SHALL update independently; simultaneous events on different channels all take effect.
REQ-023 enable=0: scores, streaks, high score unchanged regardless of strobes.
REQ-024 clear=1 SHALL zero all scores and streaks next edge, overriding enable and strobes; high score retained.
REQ-025 Internal binary high score SHALL load max over channels of registered scores when that max exceeds it, one cycle after the score register changes; it never decreases except by reset.
REQ-026 score_bcd and leader SHALL be registered conversions of the score registers, valid one cycle after a score update (latency 1).
REQ-027 high_score_bcd SHALL be a registered conversion of the binary high score (latency 2 from the causing hit edge).
REQ-028 leader SHALL select the lowest channel index on ties; 0 when all scores zero.
REQ-029 Binary-to-BCD conversion SHALL be exact for all values 0..MAX_SCORE.

Reset
REQ-030 rst_n low SHALL asynchronously clear all scores, streaks, high score, score_bcd, combo_active, high_score_bcd and leader to 0.
REQ-031 Reset asserted mid-game SHALL discard all state, including high score; first event after release counts from 0.

Verification (defaults: NUM_CH=2, DIGITS=2, MAX_SCORE=99, COMBO_LEN=4, MISS_PENALTY=1)
REQ-032 Reset then idle 5 cycles -> score_bcd=0x0000, high_score_bcd=0x00, combo_active=0, leader=0.
REQ-033 Five consecutive ch0 hits with enable=1 -> ch0 scores 1,2,3,4,6; combo_active[0] high after 4th hit; score_bcd[7:0]=0x06, leader=0.
REQ-034 ch1 at 0 with combo armed, miss -> score stays 0x00, combo_active[1]=0; then ch1 hit -> 0x01.
REQ-035 ch0 at 98 combo armed, hit -> 99 (not 100); two more hits -> holds 0x99; high_score_bcd=0x99 two cycles after first.
REQ-036 ch0=37, ch1=12, pulse clear -> both scores 0x00, combo_active=0, high_score_bcd remains 0x37, leader=0.
REQ-037 Same-cycle hit+miss on ch1 at 5 -> 4, streak 0; strobes with enable=0 -> no change; rst_n low mid-game -> all outputs 0 immediately.
